tarea1_cpu_sram_burst: RTL and testbench
========================================

TAREA1_CPU_SRAM_BURST -- requirements
Module: tarea1_cpu_sram_burst

Interface
REQ-001 Parameter DATA_W, default 32, SHALL be the data word width in bits, a multiple of 8 (8..128).
REQ-002 Parameter DEPTH, default 10240, SHALL be the number of words, 2..2**ADDR_W.
REQ-003 Parameter ADDR_W, default 14, SHALL be the word-address width.
REQ-004 Parameter READ_LATENCY, default 1, SHALL be the accept-to-readdatavalid delay in cycles, legal values 1 or 2.
REQ-005 Parameter BURST_W, default 4, SHALL be the burstcount width; max burst length is 2**(BURST_W-1).
REQ-006 Parameter INIT_FILE, default "Tarea1_CPU_SRAM.hex", SHALL be the memory init file; empty string means no init.
REQ-007 Ports SHALL be as follows; one clock; reset is synchronous and active-low:
- clk  in  1  sole clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- address  in  ADDR_W  word address of command
- byteenable  in  DATA_W/8  write byte lanes
- chipselect  in  1  slave select
- read  in  1  read command
- write  in  1  write command
- writedata  in  DATA_W  write data
- burstcount  in  BURST_W  read burst length in words
- clken  in  1  clock enable; low freezes all state
- readdata  out  DATA_W  read data
- readdatavalid  out  1  readdata qualifier, one pulse per beat
- waitrequest  out  1  command stall

Function
REQ-008 A command SHALL be accepted on a rising edge where chipselect=1, (read|write)=1, waitrequest=0, clken=1.
REQ-009 An accepted write SHALL update only lanes with byteenable[i]=1 at address; burstcount is ignored for writes (single beat).
REQ-010 If read and write are both 1 on an accepted cycle, the write SHALL be performed and the read discarded (no readdatavalid).
REQ-011 Burstcount 0 SHALL be treated as 1; values above 2**(BURST_W-1) SHALL be clamped to 2**(BURST_W-1).
REQ-012 Sequencer SHALL have states IDLE and BURST; IDLE->BURST on accepted read with effective length L>1; BURST->IDLE after the last beat is issued.
REQ-013 Beat k (k=0..L-1) SHALL read address+k; an address reaching DEPTH SHALL wrap to 0.
REQ-014 Beat 0 SHALL be issued in the accept cycle; beats 1..L-1 SHALL be issued one per enabled cycle with no gaps.
REQ-015 waitrequest SHALL be 1 in BURST state and 0 in IDLE (outside reset).
REQ-016 readdatavalid SHALL assert exactly READ_LATENCY enabled cycles after each beat issue, with readdata holding that beat's word; beats return in order.
REQ-017 When readdatavalid=0, readdata SHALL hold its previous value.
REQ-018 A read from a commanded address >= DEPTH SHALL return all-zeros data with normal readdatavalid timing; a write there SHALL be discarded.
REQ-019 A read issued in the same cycle as a write to the same address SHALL return the old (pre-write) data.
REQ-020 When clken=0, sequencer, beat counter, latency pipeline, readdatavalid and memory SHALL all hold, no command SHALL be accepted, and waitrequest SHALL be 1.
REQ-021 Memory SHALL be inferable as block RAM: one registered read port, one byte-enabled write port.

Reset
REQ-022 While reset_n=0 at a rising edge: state->IDLE, beat counter->0, latency pipeline cleared, readdatavalid->0, readdata->0, waitrequest->1.
REQ-023 The first cycle after reset_n returns to 1 SHALL show waitrequest=0.
REQ-024 Reset mid-burst SHALL abort the burst; no further readdatavalid pulses from it.
REQ-025 Reset SHALL NOT alter memory contents.

Verification
REQ-026 Write 0xAABBCCDD to addr 5 with byteenable=4'b0101, then read 5, READ_LATENCY=1 -> readdata=0xxxBBxxDD pattern (lanes 1,3 unchanged), readdatavalid one cycle after accept.
REQ-027 Read burst addr 10238, burstcount 4, DEPTH=10240 -> words from 10238, 10239, 0, 1 on 4 consecutive readdatavalid pulses; waitrequest=1 for 3 cycles.
REQ-028 burstcount=0 and burstcount=15 (BURST_W=4) -> exactly 1 and 8 readdatavalid pulses respectively.
REQ-029 Simultaneous read+write to addr 3 (old 0x11, new 0x22) -> no readdatavalid; subsequent read returns 0x22.
REQ-030 clken=0 for 3 cycles mid-burst with READ_LATENCY=2 -> pulses stretched by 3 cycles, no beat lost or duplicated, waitrequest=1 throughout the freeze.
REQ-031 reset_n=0 at beat 2 of an 8-beat burst -> readdatavalid=0 from next edge, waitrequest=0 one cycle after release, memory unchanged.

Source files
------------

// File: rtl/tarea1_cpu_sram_burst.sv
// Single-port SRAM slave with byte-enabled writes and incrementing read bursts.
// Reads are issued one beat per enabled cycle and return after READ_LATENCY cycles.
module tarea1_cpu_sram_burst #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 10240,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BURST_W      = 4,
    parameter              INIT_FILE    = "Tarea1_CPU_SRAM.hex"
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic                clken,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest
);

    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned MAX_LEN = 1 << (BURST_W - 1);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state, w_state_nx;
    logic [BURST_W-1:0]  r_cnt, w_cnt_nx, w_len;
    logic [ADDR_W-1:0]   r_addr, w_addr_nx, w_rd_addr;
    logic                r_rst_wait;
    logic                w_wait, w_accept, w_issue, w_rd_oob, w_wr_en;
    logic [DATA_W-1:0]   r_ram_q;
    logic                r_rv1;

    // Memory initialisation is handed to the RAM compiler through this attribute.
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Next word address with wrap at the end of the populated range.
    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + (ADDR_W + 1)'(1);
        return (s >= DEPTH_X) ? '0 : s[ADDR_W-1:0];
    endfunction

    // Effective burst length: 0 counts as 1, oversize requests are clamped.
    always_comb begin
        w_len = burstcount;
        if (burstcount == '0) begin
            w_len = BURST_W'(1);
        end else if (burstcount > BURST_W'(MAX_LEN)) begin
            w_len = BURST_W'(MAX_LEN);
        end
    end

    // Stall while leaving reset, mid-burst, or with the clock enable low.
    assign w_wait      = r_rst_wait | (r_state == S_BURST) | ~clken;
    assign waitrequest = w_wait;
    assign w_accept    = chipselect & (read | write) & ~w_wait;
    assign w_wr_en     = w_accept & write & ({1'b0, address} < DEPTH_X);
    assign w_rd_oob    = ({1'b0, w_rd_addr} >= DEPTH_X);

    // Sequencer next state, beat issue and read address selection.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_addr_nx  = r_addr;
        w_issue    = 1'b0;
        w_rd_addr  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (w_accept && read && !write) begin
                    w_issue   = 1'b1;
                    w_rd_addr = address;
                    if (w_len > BURST_W'(1)) begin
                        w_state_nx = S_BURST;
                        w_cnt_nx   = w_len - BURST_W'(1);
                        w_addr_nx  = f_next(address);
                    end
                end
            end
            S_BURST: begin
                if (clken) begin
                    w_issue   = 1'b1;
                    w_addr_nx = f_next(r_addr);
                    w_cnt_nx  = r_cnt - BURST_W'(1);
                    if (r_cnt == BURST_W'(1)) begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Sequencer state register; frozen while clken is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rst_wait <= 1'b1;
        end else if (clken) begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_addr     <= w_addr_nx;
            r_rst_wait <= 1'b0;
        end
    end

    // Byte-enabled write port; untouched by reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (byteenable[i]) begin
                    r_mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read port; out-of-range beats return zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ram_q <= '0;
            r_rv1   <= 1'b0;
        end else if (clken) begin
            r_rv1 <= w_issue;
            if (w_issue) begin
                r_ram_q <= w_rd_oob ? '0 : r_mem[w_rd_addr];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] r_rdata2;
            logic              r_rv2;

            // Second pipeline stage; data only moves on a valid beat.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_rdata2 <= '0;
                    r_rv2    <= 1'b0;
                end else if (clken) begin
                    r_rv2 <= r_rv1;
                    if (r_rv1) begin
                        r_rdata2 <= r_ram_q;
                    end
                end
            end

            assign readdata      = r_rdata2;
            assign readdatavalid = r_rv2;
        end else begin : g_lat1
            assign readdata      = r_ram_q;
            assign readdatavalid = r_rv1;
        end
    endgenerate

endmodule

// File: tb/tb_tarea1_cpu_sram_burst.sv
// Directed bench for tarea1_cpu_sram_burst: one latency-1 and one latency-2 instance share stimulus.
module tb_tarea1_cpu_sram_burst;

    localparam int unsigned DEPTH = 10240;

    logic        clk;
    logic        reset_n;
    logic [13:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  burstcount;
    logic        clken;
    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2;
    logic        wait1, wait2;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m [0:DEPTH-1];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [3:0]  bc;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [13];

    tarea1_cpu_sram_burst #(.READ_LATENCY(1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .burstcount(burstcount), .clken(clken), .readdata(rdata1),
        .readdatavalid(rvalid1), .waitrequest(wait1)
    );

    tarea1_cpu_sram_burst #(.READ_LATENCY(2), .INIT_FILE("")) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .burstcount(burstcount), .clken(clken), .readdata(rdata2),
        .readdatavalid(rvalid2), .waitrequest(wait2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic mdl_write(input int a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] t;
        if (a < int'(DEPTH)) begin
            t = m[a];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) t[i*8 +: 8] = wd[i*8 +: 8];
            end
            m[a] = t;
        end
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        address    = 14'(a);
        byteenable = 4'hF;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write      = 1'b0;
        mdl_write(a, 4'hF, d);
    endtask

    // Issue one read burst and watch up to 20 cycles, optionally freezing clken.
    task automatic run_burst(input int a, input logic [3:0] bc, input int exp_len,
                             input bit lat2, input int fz_start, input int fz_n, input string nm);
        int beats = 0;
        int first = -1;
        int last  = -1;
        int wcnt  = 0;
        logic        v, w;
        logic [31:0] d;
        address    = 14'(a);
        burstcount = bc;
        chipselect = 1'b1;
        read       = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        for (int j = 0; j < 20; j++) begin
            clken = !(j >= fz_start && j < fz_start + fz_n);
            #1;
            v = lat2 ? rvalid2 : rvalid1;
            d = lat2 ? rdata2  : rdata1;
            w = lat2 ? wait2   : wait1;
            if (!clken) chk($sformatf("%s_frz_wait%0d", nm, j), 32'(w), 32'(1));
            if (clken && w) wcnt++;
            if (clken && v) begin
                if (beats < exp_len)
                    chk($sformatf("%s_beat%0d", nm, beats), d, m[(a + beats) % int'(DEPTH)]);
                if (first < 0) first = j;
                last = j;
                beats++;
            end
            @(posedge clk); #1;
        end
        clken = 1'b1;
        chk($sformatf("%s_nbeats", nm), 32'(beats), 32'(exp_len));
        chk($sformatf("%s_nwait", nm), 32'(wcnt), 32'(exp_len - 1));
        chk($sformatf("%s_span", nm), 32'(last - first + 1), 32'(exp_len + fz_n));
    endtask

    initial begin
        int cnt;
        clk        = 1'b0;
        reset_n    = 1'b0;
        clken      = 1'b1;
        address    = '0;
        byteenable = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        burstcount = '0;

        //            rd    wr    addr        be    wdata          bc    ev    ed
        vecs[0]  = '{1'b0, 1'b1, 14'd5,     4'hF, 32'h11111111, 4'd1, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, 14'd5,     4'h5, 32'hAABBCCDD, 4'd1, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 14'd5,     4'h0, 32'h00000000, 4'd1, 1'b1, 32'h11BB11DD};
        vecs[3]  = '{1'b0, 1'b1, 14'd3,     4'hF, 32'h00000011, 4'd1, 1'b0, 32'h11BB11DD};
        vecs[4]  = '{1'b1, 1'b1, 14'd3,     4'hF, 32'h00000022, 4'd1, 1'b0, 32'h11BB11DD};
        vecs[5]  = '{1'b1, 1'b0, 14'd3,     4'h0, 32'h00000000, 4'd1, 1'b1, 32'h00000022};
        vecs[6]  = '{1'b1, 1'b0, 14'd12000, 4'h0, 32'h00000000, 4'd1, 1'b1, 32'h00000000};
        vecs[7]  = '{1'b0, 1'b1, 14'd12000, 4'hF, 32'hDEADBEEF, 4'd1, 1'b0, 32'h00000000};
        vecs[8]  = '{1'b1, 1'b0, 14'd12000, 4'h0, 32'h00000000, 4'd1, 1'b1, 32'h00000000};
        vecs[9]  = '{1'b1, 1'b0, 14'd5,     4'h0, 32'h00000000, 4'd0, 1'b1, 32'h11BB11DD};
        vecs[10] = '{1'b1, 1'b0, 14'd9,     4'h0, 32'h00000000, 4'd1, 1'b1, 32'hC0DE0009};
        vecs[11] = '{1'b0, 1'b1, 14'd9,     4'h8, 32'h77000000, 4'd1, 1'b0, 32'hC0DE0009};
        vecs[12] = '{1'b1, 1'b0, 14'd9,     4'h0, 32'h00000000, 4'd1, 1'b1, 32'h77DE0009};

        // Reset state, then first cycle after release.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid1", 32'(rvalid1), 32'(0));
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_wait1", 32'(wait1), 32'(1));
        chk("rst_valid2", 32'(rvalid2), 32'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_wait1", 32'(wait1), 32'(0));
        chk("rel_wait2", 32'(wait2), 32'(0));

        // Known contents around both ends of the array.
        for (int a = 0; a < 10; a++) write_word(a, 32'hC0DE0000 + 32'(a));
        write_word(10238, 32'hC0DE0000 + 32'(10238));
        write_word(10239, 32'hC0DE0000 + 32'(10239));

        // Single-beat vectors on the latency-1 instance.
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("v%0d_wait", i), 32'(wait1), 32'(0));
            address    = vecs[i].addr;
            byteenable = vecs[i].be;
            writedata  = vecs[i].wd;
            burstcount = vecs[i].bc;
            read       = vecs[i].rd;
            write      = vecs[i].wr;
            chipselect = 1'b1;
            @(posedge clk); #1;
            chipselect = 1'b0;
            read       = 1'b0;
            write      = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(rvalid1), 32'(vecs[i].ev));
            chk($sformatf("v%0d_data", i), rdata1, vecs[i].ed);
            if (vecs[i].wr) mdl_write(int'(vecs[i].addr), vecs[i].be, vecs[i].wd);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_after", i), 32'(rvalid1), 32'(0));
            chk($sformatf("v%0d_hold", i), rdata1, vecs[i].ed);
        end

        // Bursts: wrap at the top, zero length, clamped length.
        run_burst(10238, 4'd4, 4, 1'b0, 100, 0, "wrap");
        run_burst(0, 4'd0, 1, 1'b0, 100, 0, "bc0");
        run_burst(0, 4'd15, 8, 1'b0, 100, 0, "bc15");

        // Latency-2 burst with a three-cycle clken freeze in the middle.
        run_burst(0, 4'd8, 8, 1'b1, 4, 3, "frz");

        // Reset arriving at beat 2 of an 8-beat burst.
        address    = 14'd0;
        burstcount = 4'd8;
        chipselect = 1'b1;
        read       = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        chk("abort_b0_valid", 32'(rvalid1), 32'(1));
        chk("abort_b0_data", rdata1, m[0]);
        @(posedge clk); #1;
        chk("abort_b1_data", rdata1, m[1]);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid1", 32'(rvalid1), 32'(0));
        chk("abort_rdata1", rdata1, 32'h0);
        chk("abort_wait1", 32'(wait1), 32'(1));
        chk("abort_valid2", 32'(rvalid2), 32'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_wait", 32'(wait1), 32'(0));
        cnt = 0;
        for (int j = 0; j < 6; j++) begin
            if (rvalid1 || rvalid2) cnt++;
            @(posedge clk); #1;
        end
        chk("abort_no_pulses", 32'(cnt), 32'(0));

        // Memory survives reset.
        run_burst(0, 4'd8, 8, 1'b0, 100, 0, "post_rst");
        run_burst(10238, 4'd2, 2, 1'b1, 100, 0, "post_rst_top");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
